// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl
// ----------------------------------------------------------------------------
// Pipeline sequencing controller for the 5-stage core.
//   * Detects load-use hazards on the instruction held in IF/ID.
//   * Sequences the IF/ID flush after a taken branch / jump resolved in EX.
//   * Freezes the whole pipe while data memory is not ready.
//   * Keeps saturating debug counters of stall cycles and redirect events.
//
// Parameters:
//   FLUSH_CYC  extra cycles after the redirect cycle during which IF/ID is
//              held flushed (instruction-memory latency), 0..15
//   CNT_W      width of the event counters
//
// Ports:
//   clk              in   core clock, rising edge
//   rst              in   synchronous active-high reset
//   id_instr[31:0]   in   instruction currently in IF/ID
//   id_valid         in   IF/ID holds a real instruction
//   ex_mem_read      in   ID/EX instruction is a load
//   ex_rd[4:0]       in   destination register of the ID/EX instruction
//   ex_branch_taken  in   redirect (taken branch, JAL, JALR) resolved in EX
//   dmem_ready       in   data memory completes this cycle (0 = stall pipe)
//   pc_we            out  PC load enable
//   if_id_we         out  IF/ID load enable
//   if_id_flush      out  IF/ID loads a bubble at the next edge
//   id_ex_bubble     out  ID/EX loads a bubble instead of decode output
//   pipe_freeze      out  hold ID/EX, EX/MEM and MEM/WB
//   stall_cnt        out  load-use stall cycles, saturating
//   flush_cnt        out  redirect events, saturating
// ============================================================================
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYC = 1,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    // Only the low four bits are meaningful; legal values are 0..15.
    localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    // RISC-V base opcodes recognised by decode
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;      // state to resume after a freeze
    state_t           eff_state;
    logic [3:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // ------------------------------------------------------------------------
    // Source-register usage of the IF/ID instruction
    // ------------------------------------------------------------------------
    logic [6:0] opcode;
    logic       uses_rs1;
    logic       uses_rs2;
    logic [1:0] src_used;
    logic [1:0] src_hit;
    logic       lu;

    assign opcode = id_instr[6:0];

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
            OP_STORE, OP_BRANCH, OP_REG: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            // LUI, JAL and anything unrecognised read no register; the
            // rs fields of those encodings hold immediate bits.
            default: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

    assign src_used = {uses_rs2, uses_rs1};

    // rs1 lives at [19:15], rs2 at [24:20]
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic [4:0] src_reg;
        assign src_reg     = id_instr[15 + 5*gi +: 5];
        assign src_hit[gi] = src_used[gi] && (src_reg == ex_rd);
    end

    // x0 is never a real dependency
    assign lu = id_valid && ex_mem_read && (ex_rd != 5'd0) && (|src_hit);

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    // Coming out of FREEZE the controller acts as the saved state in the same
    // cycle, so the freeze never costs an extra bubble.
    assign eff_state = (state_q == ST_FREEZE) ? ret_q : state_q;

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        fcnt_d       = fcnt_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;

        if (rst) begin
            // Hold the front end and keep bubbles flowing; the sequential
            // block restores the idle state at the edge.
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            pipe_freeze  = 1'b0;
        end else if (!dmem_ready) begin
            // Whole pipe holds; a redirect in EX stays there and is picked up
            // once memory completes.
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
            pipe_freeze  = 1'b1;
            state_d      = ST_FREEZE;
            ret_d        = eff_state;
        end else if (eff_state == ST_FLUSH) begin
            // EX only holds bubbles here, so a redirect cannot be genuine
            // and ex_branch_taken is not looked at.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            fcnt_d       = (fcnt_q == 4'd0) ? 4'd0 : fcnt_q - 4'd1;
            state_d      = (fcnt_q <= 4'd1) ? ST_RUN : ST_FLUSH;
        end else begin
            state_d = ST_RUN;
            if (ex_branch_taken) begin
                // IF/ID holds a wrong-path instruction; any hazard on it is moot.
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                flush_cnt_d  = (flush_cnt_q == CNT_MAX) ? flush_cnt_q
                                                        : flush_cnt_q + CNT_ONE;
                if (FLUSH_CYC > 0) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FLUSH_INIT;
                end
            end else if (lu) begin
                // The inserted bubble clears ex_mem_read next cycle, so each
                // hazard costs exactly one stall.
                pc_we        = 1'b0;
                if_id_we     = 1'b0;
                id_ex_bubble = 1'b1;
                stall_cnt_d  = (stall_cnt_q == CNT_MAX) ? stall_cnt_q
                                                        : stall_cnt_q + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            ret_q       <= ST_RUN;
            fcnt_q      <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl
// Directed bench for hazard_ctrl (FLUSH_CYC=2, CNT_W=3). Each step applies
// inputs just after a rising edge, checks the control outputs at the falling
// edge, then checks both event counters just after the next rising edge.
// ============================================================================
module tb_hazard_ctrl;

    localparam int unsigned FLUSH_CYC = 2;
    localparam int unsigned CNT_W     = 3;

    // control vector {pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_freeze}
    localparam logic [4:0] O_RUN   = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00010;
    localparam logic [4:0] O_FLUSH = 5'b11110;
    localparam logic [4:0] O_FRZ   = 5'b00001;
    localparam logic [4:0] O_RST   = 5'b00110;

    localparam logic [31:0] I_ADD   = 32'h006283B3; // add  x7,x5,x6
    localparam logic [31:0] I_ADDX0 = 32'h00600333; // add  x6,x0,x6
    localparam logic [31:0] I_LUI   = 32'h000052B7; // lui  x5,5
    localparam logic [31:0] I_LUI5  = 32'h000282B7; // lui  with 5 in rs1 field
    localparam logic [31:0] I_JAL5  = 32'h000282EF; // jal  with 5 in rs1 field
    localparam logic [31:0] I_ADDI2 = 32'h00508013; // addi x0,x1,5 (5 in rs2 field)
    localparam logic [31:0] I_ADDI5 = 32'h00028013; // addi x0,x5,0
    localparam logic [31:0] I_SW5   = 32'h00500023; // sw   x5,0(x0)
    localparam logic [31:0] I_BEQ5  = 32'h00500063; // beq  x0,x5
    localparam logic [31:0] I_JALR5 = 32'h00028067; // jalr x0,0(x5)
    localparam logic [31:0] I_LW5   = 32'h00028003; // lw   x0,0(x5)

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      id_instr;
    logic             id_valid;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;
    logic             dmem_ready;
    logic             pc_we;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pipe_freeze;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int checks   = 0;
    int failures = 0;
    logic [CNT_W-1:0] exp_stall = '0;
    logic [CNT_W-1:0] exp_flush = '0;
    logic             flush_phase = 1'b0;  // bench is inside a FLUSH window

    logic [4:0] ctl;
    assign ctl = {pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_freeze};

    always #5 clk = ~clk;

    hazard_ctrl #(
        .FLUSH_CYC(FLUSH_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_instr       (id_instr),
        .id_valid       (id_valid),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .dmem_ready     (dmem_ready),
        .pc_we          (pc_we),
        .if_id_we       (if_id_we),
        .if_id_flush    (if_id_flush),
        .id_ex_bubble   (id_ex_bubble),
        .pipe_freeze    (pipe_freeze),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    // A redirect while EX only holds bubbles would be an illegal stimulus.
    always @(posedge clk) begin
        if (!rst)
            assert (!(flush_phase && ex_branch_taken))
                else $error("illegal stimulus: redirect inside flush window");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    task automatic set_in(input logic [31:0] instr, input logic valid,
                          input logic mrd, input logic [4:0] rd,
                          input logic br, input logic rdy);
        id_instr        = instr;
        id_valid        = valid;
        ex_mem_read     = mrd;
        ex_rd           = rd;
        ex_branch_taken = br;
        dmem_ready      = rdy;
    endtask

    // One cycle: check controls mid-cycle, advance, check counters.
    task automatic step(input string tag, input logic [4:0] exp_ctl,
                        input logic inc_s, input logic inc_f);
        @(negedge clk);
        checks++;
        assert (ctl === exp_ctl) else begin
            failures++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, ctl, exp_ctl);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            exp_stall = '0;
            exp_flush = '0;
        end else begin
            if (inc_s) exp_stall = sat_inc(exp_stall);
            if (inc_f) exp_flush = sat_inc(exp_flush);
        end
        checks++;
        assert (stall_cnt === exp_stall) else begin
            failures++;
            $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, exp_stall);
        end
        checks++;
        assert (flush_cnt === exp_flush) else begin
            failures++;
            $error("FAIL %s flush_cnt observed=%0d expected=%0d", tag, flush_cnt, exp_flush);
        end
        $display("step %-12s ctl=%b stall_cnt=%0d flush_cnt=%0d", tag, ctl, stall_cnt, flush_cnt);
    endtask

    initial begin
        // ---- reset with random inputs ----
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in($urandom, 1'($urandom), 1'($urandom), 5'($urandom),
                   1'($urandom), 1'($urandom));
            step("reset", O_RST, 1'b0, 1'b0);
        end
        rst = 1'b0;
        set_in(I_ADD, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        step("release", O_RUN, 1'b0, 1'b0);

        // ---- load-use hazards ----
        set_in(I_ADD, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
        step("lu_rs1", O_STALL, 1'b1, 1'b0);
        set_in(I_ADD, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        step("lu_bubble", O_RUN, 1'b0, 1'b0);
        set_in(I_ADD, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1);
        step("lu_rs2", O_STALL, 1'b1, 1'b0);

        // ---- no false hazards ----
        set_in(I_ADDX0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
        step("nh_rd0", O_RUN, 1'b0, 1'b0);
        set_in(I_ADD, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
        step("nh_invalid", O_RUN, 1'b0, 1'b0);
        set_in(I_LUI, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
        step("nh_lui", O_RUN, 1'b0, 1'b0);
        set_in(I_LUI5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
        step("nh_lui5", O_RUN, 1'b0, 1'b0);
        set_in(I_JAL5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
        step("nh_jal5", O_RUN, 1'b0, 1'b0);
        set_in(I_ADDI2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
        step("nh_addi_rs2", O_RUN, 1'b0, 1'b0);
        set_in(I_ADD, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1);
        step("nh_rdmiss", O_RUN, 1'b0, 1'b0);

        // ---- hazards per opcode class (stall_cnt: 2 -> 6, saturates at 7) ----
        set_in(I_ADDI5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
        step("lu_addi", O_STALL, 1'b1, 1'b0);
        set_in(I_SW5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
        step("lu_sw", O_STALL, 1'b1, 1'b0);
        set_in(I_BEQ5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
        step("lu_beq", O_STALL, 1'b1, 1'b0);
        set_in(I_JALR5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
        step("lu_jalr", O_STALL, 1'b1, 1'b0);

        // ---- redirect with simultaneous lu: 3 flushed cycles ----
        set_in(I_ADD, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
        step("redirect", O_FLUSH, 1'b0, 1'b1);
        flush_phase = 1'b1;
        set_in(I_ADD, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
        step("flush1", O_FLUSH, 1'b0, 1'b0);
        step("flush2", O_FLUSH, 1'b0, 1'b0);
        flush_phase = 1'b0;
        set_in(I_ADD, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        step("post_flush", O_RUN, 1'b0, 1'b0);

        // ---- freeze in the middle of a flush ----
        set_in(I_ADD, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
        step("redir2", O_FLUSH, 1'b0, 1'b1);
        flush_phase = 1'b1;
        set_in(I_ADD, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        step("r2_flush1", O_FLUSH, 1'b0, 1'b0);
        dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step("r2_freeze", O_FRZ, 1'b0, 1'b0);
        dmem_ready = 1'b1;
        step("r2_flush2", O_FLUSH, 1'b0, 1'b0);
        flush_phase = 1'b0;
        step("r2_run", O_RUN, 1'b0, 1'b0);

        // ---- freeze in RUN hides a pending redirect until memory is ready ----
        set_in(I_ADD, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        step("frz_br", O_FRZ, 1'b0, 1'b0);
        dmem_ready = 1'b1;
        step("frz_br_go", O_FLUSH, 1'b0, 1'b1);
        flush_phase = 1'b1;
        ex_branch_taken = 1'b0;
        step("r3_flush1", O_FLUSH, 1'b0, 1'b0);
        step("r3_flush2", O_FLUSH, 1'b0, 1'b0);
        flush_phase = 1'b0;
        step("r3_run", O_RUN, 1'b0, 1'b0);

        // ---- freeze over a load-use hazard, then exactly one stall ----
        set_in(I_LW5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        step("frz_lu", O_FRZ, 1'b0, 1'b0);
        dmem_ready = 1'b1;
        step("frz_lu_go", O_STALL, 1'b1, 1'b0);
        ex_mem_read = 1'b0;
        step("frz_lu_run", O_RUN, 1'b0, 1'b0);

        // ---- stall counter saturation ----
        for (int i = 0; i < 3; i++) begin
            set_in(I_ADD, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
            step("sat_lu", O_STALL, 1'b1, 1'b0);
            ex_mem_read = 1'b0;
            step("sat_run", O_RUN, 1'b0, 1'b0);
        end

        // ---- flush counter saturation ----
        for (int i = 0; i < 5; i++) begin
            set_in(I_ADD, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
            step("sat_redir", O_FLUSH, 1'b0, 1'b1);
            flush_phase = 1'b1;
            ex_branch_taken = 1'b0;
            step("sat_flush", O_FLUSH, 1'b0, 1'b0);
            step("sat_flush", O_FLUSH, 1'b0, 1'b0);
            flush_phase = 1'b0;
        end
        step("sat_done", O_RUN, 1'b0, 1'b0);

        // ---- reset in the middle of a flush abandons it ----
        set_in(I_ADD, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
        step("rf_redir", O_FLUSH, 1'b0, 1'b1);
        flush_phase = 1'b1;
        ex_branch_taken = 1'b0;
        rst = 1'b1;
        step("rf_reset", O_RST, 1'b0, 1'b0);
        rst = 1'b0;
        flush_phase = 1'b0;
        step("rf_run", O_RUN, 1'b0, 1'b0);

        // ---- reset in the middle of a freeze ----
        dmem_ready = 1'b0;
        step("rz_freeze", O_FRZ, 1'b0, 1'b0);
        rst = 1'b1;
        step("rz_reset", O_RST, 1'b0, 1'b0);
        rst = 1'b0;
        dmem_ready = 1'b1;
        step("rz_run", O_RUN, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core. It detects load-use hazards on the instruction held in IF/ID, using the same opcode classes the decode/immediate logic recognises.
- It sequences the flush after a taken branch or jump resolved in EX, and freezes the whole pipe while data memory is not ready.
- It drives the write-enable, flush and bubble controls of the PC, IF/ID and ID/EX registers, and keeps saturating stall/flush event counters for debug.

Parameters:
- FLUSH_CYC, 1: extra cycles after the redirect cycle during which IF/ID is held flushed (instruction-memory latency). Legal range 0..15.
- CNT_W, 32: width of the event counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_instr  in  32  instruction currently in IF/ID.
- id_valid  in  1  IF/ID holds a real instruction.
- ex_mem_read  in  1  instruction in ID/EX is a load (opcode 0000011).
- ex_rd  in  5  destination register of the ID/EX instruction.
- ex_branch_taken  in  1  SB-type taken branch, JAL or JALR redirect resolved in EX this cycle.
- dmem_ready  in  1  data memory can complete this cycle; 0 stalls the pipe.
- pc_we  out  1  PC register load enable.
- if_id_we  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads a bubble (id_valid=0) at the next edge.
- id_ex_bubble  out  1  ID/EX loads a NOP/bubble instead of decode output.
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB unchanged.
- stall_cnt  out  CNT_W  number of load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  number of redirect events, saturating.

Behaviour:
- The state register takes one of three states: RUN, FLUSH or FREEZE. Outputs are a combinational decode of state and inputs. There is a flush-down counter fcnt of 4 bits.
- Reset (rst=1 at an edge) sets state=RUN, fcnt=0, stall_cnt=0 and flush_cnt=0.
- While rst is high, outputs are forced to pc_we=0, if_id_we=0, if_id_flush=1, id_ex_bubble=1 and pipe_freeze=0. Reset mid-flush or mid-freeze abandons the operation without a counter update.
- Source-register usage by id_instr[6:0]:
  - rs1 (bits 19:15) is used by 0010011, 0000011, 0100011, 1100011, 0110011 and 1100111.
  - rs2 (bits 24:20) is used by 0100011, 1100011 and 0110011.
  - 0110111 and 1101111 use neither.
- Load-use hazard (lu) = id_valid & ex_mem_read & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- Priority each cycle: rst > dmem_ready=0 > redirect > load-use > normal.
- Any state with dmem_ready=0:
  - Outputs: pipe_freeze=1, pc_we=0, if_id_we=0, if_id_flush=0, id_ex_bubble=0.
  - Go to FREEZE, saving the return state. fcnt holds and no counter changes.
  - ex_branch_taken is ignored while frozen; EX is held, so the signal persists.
- FREEZE with dmem_ready=1: behave as the saved state (RUN or FLUSH) in this same cycle. There is no extra bubble.
- RUN with ex_branch_taken=1:
  - Outputs: pc_we=1, if_id_we=1, if_id_flush=1, id_ex_bubble=1. lu is ignored because the ID instruction is wrong-path.
  - flush_cnt increments.
  - If FLUSH_CYC>0, go to FLUSH with fcnt=FLUSH_CYC; otherwise stay in RUN.
- RUN with lu=1: pc_we=0, if_id_we=0, id_ex_bubble=1, if_id_flush=0. stall_cnt increments. Exactly one stall cycle occurs per hazard, because the bubble clears ex_mem_read.
- RUN otherwise: pc_we=1, if_id_we=1, if_id_flush=0, id_ex_bubble=0.
- FLUSH:
  - Outputs: pc_we=1, if_id_we=1, if_id_flush=1, id_ex_bubble=1.
  - fcnt decrements each cycle; when fcnt==1, return to RUN.
  - ex_branch_taken=1 in FLUSH is illegal (EX holds bubbles). It is ignored and flagged by a bench assertion.
- Counters saturate at all-ones and never wrap.

Test Plan:
- Reset: hold rst 3 cycles with random inputs -> counters=0, pc_we=0, if_id_flush=1, id_ex_bubble=1; first cycle after release with no hazard -> pc_we=if_id_we=1.
- Load-use: ex_mem_read=1, ex_rd=5, id_instr=add x7,x5,x6 (0x006283B3), id_valid=1 -> one cycle pc_we=0, if_id_we=0, id_ex_bubble=1, stall_cnt=1.
- No false hazard: ex_rd=0, or lui x5 (0x000052B7) in ID with ex_rd=5 -> no stall, stall_cnt stays 0.
- Redirect with FLUSH_CYC=2: ex_branch_taken pulse together with an lu condition -> 3 consecutive cycles of if_id_flush=1, flush_cnt=1, stall_cnt=0, then RUN.
- Freeze mid-flush: dmem_ready=0 for 4 cycles during FLUSH -> pipe_freeze=1, pc_we=0 for 4 cycles; remaining flush cycles resume afterwards with the total flush count unchanged.
- Saturation: CNT_W=3, 9 load-use events -> stall_cnt=7.
